// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue path:
//   - alu_issue_state_e : issue sequencer FSM states
//   - RS_SEL_RS1/RS2    : encoding of the rs_data_sel operand select
//   - ALU_* widths      : default widths shared with the ALU interface
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_BUS_WIDTH      = 32;
    localparam int ALU_OPCODE_WIDTH   = 4;
    localparam int ALU_REG_ADDR_WIDTH = 5;
    localparam int ALU_TIMEOUT_CYCLES = 256;

    localparam logic RS_SEL_RS1 = 1'b0;
    localparam logic RS_SEL_RS2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_RS1  = 3'd1,
        ST_SEND_RS2  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_WRITEBACK = 3'd4
    } alu_issue_state_e;

endpackage : alu_pkg

// File: rtl/alu_issue_timer.sv
// -----------------------------------------------------------------------------
// alu_issue_timer
// WAIT_DONE watchdog for alu_issue_seq. Only instantiated when the
// ALU_ISSUE_TIMEOUT_EN macro is defined.
// Ports:
//   clk       in  : clock, rising edge
//   rst       in  : asynchronous active-high reset
//   i_run     in  : high while the sequencer sits in WAIT_DONE
//   o_expired out : high in the TIMEOUT_CYCLES-th consecutive i_run cycle
// -----------------------------------------------------------------------------
module alu_issue_timer
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = ALU_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    // The counter rests at zero outside WAIT_DONE, so every entry starts
    // from a cleared count; the first WAIT_DONE cycle is count 0.
    // NOTE: sequential state is only ever written with <= so that every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!i_run) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_run && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule : alu_issue_timer

// File: rtl/alu_issue_seq.sv
// -----------------------------------------------------------------------------
// alu_issue_seq
// Issue sequencer in front of the ALU. Accepts one decoded instruction over a
// valid/ready handshake, serialises rs1 and then rs2 (skipped for immediate
// ops) onto the shared rs_data bus, waits for op_done, and issues a one-cycle
// writeback strobe carrying the captured ALU result.
//
// Optional feature: define ALU_ISSUE_TIMEOUT_EN to build a WAIT_DONE watchdog
// (alu_issue_timer). Without it issue_err is tied low and WAIT_DONE waits
// indefinitely.
//
// Ports (all outputs registered, all reset to 0):
//   clk, rst                 : clock / asynchronous active-high reset
//   instr_valid/instr_ready  : instruction handshake
//   instr_op/rs1/rs2/imm     : opcode and operand values
//   instr_use_imm            : 1 = immediate replaces rs2
//   instr_rd                 : destination register index
//   rs_data/_sel/_valid      : serialised operand toward the ALU
//   op_code, imme_value      : opcode and immediate toward the ALU
//   alu_out, alu_valid_out   : ALU result and its qualifier
//   op_done                  : ALU finished the current instruction
//   wb_valid/wb_rd/wb_data   : writeback strobe toward the register file
//   issue_err                : one-cycle WAIT_DONE timeout strobe
// -----------------------------------------------------------------------------
module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH      = ALU_BUS_WIDTH,
    parameter int OPCODE_WIDTH   = ALU_OPCODE_WIDTH,
    parameter int REG_ADDR_WIDTH = ALU_REG_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = ALU_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [OPCODE_WIDTH-1:0]   instr_op,
    input  logic [BUS_WIDTH-1:0]      instr_rs1,
    input  logic [BUS_WIDTH-1:0]      instr_rs2,
    input  logic [BUS_WIDTH-1:0]      instr_imm,
    input  logic                      instr_use_imm,
    input  logic [REG_ADDR_WIDTH-1:0] instr_rd,
    output logic [BUS_WIDTH-1:0]      rs_data,
    output logic                      rs_data_sel,
    output logic                      rs_data_valid,
    output logic [OPCODE_WIDTH-1:0]   op_code,
    output logic [BUS_WIDTH-1:0]      imme_value,
    input  logic [BUS_WIDTH-1:0]      alu_out,
    input  logic                      alu_valid_out,
    input  logic                      op_done,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [BUS_WIDTH-1:0]      wb_data,
    output logic                      issue_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("alu_issue_seq: TIMEOUT_CYCLES must be at least 1");
    end

    alu_issue_state_e r_state;
    alu_issue_state_e w_next_state;
    logic             w_accept;
    logic             w_issue_err;
    logic             w_timeout;
    logic             w_in_wait;

    // rs1 is needed only in SEND_RS1, the cycle right after accept, so the
    // rs_data register loads it straight from the input and no copy is kept.
    logic [OPCODE_WIDTH-1:0]   r_op;
    logic [BUS_WIDTH-1:0]      r_rs2;
    logic [BUS_WIDTH-1:0]      r_imm;
    logic                      r_use_imm;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [BUS_WIDTH-1:0]      r_result;
    logic                      r_captured;

    assign w_in_wait = (r_state == ST_WAIT_DONE);

`ifdef ALU_ISSUE_TIMEOUT_EN
    alu_issue_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_run     (w_in_wait),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state decode. All outputs are registered from the next state,
    // so each output appears in the same cycle as the state it belongs to.
    // NOTE: every variable assigned here gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_issue_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid && instr_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_SEND_RS1;
                end
            end
            ST_SEND_RS1: begin
                w_next_state = r_use_imm ? ST_WAIT_DONE : ST_SEND_RS2;
            end
            ST_SEND_RS2: begin
                w_next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // op_done wins over a timeout in the terminal-count cycle.
                if (op_done) begin
                    w_next_state = (r_captured || alu_valid_out) ? ST_WRITEBACK : ST_IDLE;
                end else if (w_timeout) begin
                    w_issue_err  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Instruction latches and result capture.
    // NOTE: the datapath registers are reset as well, so a reset can never
    // let a stale rd or result reach a later writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= '0;
            r_rs2      <= '0;
            r_imm      <= '0;
            r_use_imm  <= 1'b0;
            r_rd       <= '0;
            r_result   <= '0;
            r_captured <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op       <= instr_op;
                r_rs2      <= instr_rs2;
                r_imm      <= instr_imm;
                r_use_imm  <= instr_use_imm;
                r_rd       <= instr_rd;
                r_captured <= 1'b0;
            end else if (w_in_wait && alu_valid_out) begin
                r_result   <= alu_out;
                r_captured <= 1'b1;
            end
        end
    end

    // Registered outputs. The accept edge loads from the instruction inputs
    // directly because the latches only become valid after that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_ready   <= 1'b0;
            rs_data       <= '0;
            rs_data_sel   <= RS_SEL_RS1;
            rs_data_valid <= 1'b0;
            op_code       <= '0;
            imme_value    <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            issue_err     <= 1'b0;
        end else begin
            instr_ready   <= (w_next_state == ST_IDLE);
            rs_data_valid <= (w_next_state == ST_SEND_RS1) || (w_next_state == ST_SEND_RS2);
            rs_data_sel   <= (w_next_state == ST_SEND_RS2) ? RS_SEL_RS2 : RS_SEL_RS1;
            issue_err     <= w_issue_err;

            if (w_accept) begin
                rs_data <= instr_rs1;
            end else if (w_next_state == ST_SEND_RS2) begin
                rs_data <= r_rs2;
            end else begin
                rs_data <= '0;
            end

            if (w_accept) begin
                op_code    <= instr_op;
                imme_value <= instr_imm;
            end else if ((w_next_state == ST_SEND_RS2) || (w_next_state == ST_WAIT_DONE)) begin
                op_code    <= r_op;
                imme_value <= r_imm;
            end else begin
                op_code    <= '0;
                imme_value <= '0;
            end

            // A result arriving together with op_done is newer than any
            // earlier capture, so it takes precedence.
            if (w_next_state == ST_WRITEBACK) begin
                wb_valid <= (r_rd != '0);
                wb_rd    <= r_rd;
                wb_data  <= alu_valid_out ? alu_out : r_result;
            end else begin
                wb_valid <= 1'b0;
                wb_rd    <= '0;
                wb_data  <= '0;
            end
        end
    end

endmodule : alu_issue_seq
